grid_io_param: RTL and testbench

//  Parametrised I/O grid tile: NUM_PADS GPIO subtiles behind one configuration chain.

---
 rtl/grid_io_param.sv | 122 ++++++++++++
 tb/tb_grid_io_param.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/grid_io_param.sv
// grid_io_param: I/O grid tile with NUM_PADS GPIO subtiles on one config chain.
// A serial shift chain is loaded through ccff_head and copied into a shadow
// register on ccff_commit, but only when exactly TOTAL bits were shifted in.
// Only the shadow drives the pads, so loading a new config never disturbs them.
// Ports:
//   prog_clk, pReset          clock, synchronous active-high reset
//   ccff_head / ccff_tail     serial config in / chain[TOTAL-1] out
//   ccff_shift_en/ccff_commit shift one bit / commit chain into shadow
//   io_outpad / io_inpad      fabric->pad / pad->fabric data, one bit per pad
//   gfpga_pad_GPIO_PAD        physical pads (tristate)
//   cfg_valid / cfg_err       shadow committed / last commit rejected (sticky)

// One GPIO subtile. It holds the input sample flop and the input mux. The pad
// driver lives in the parent so that all tristate logic stays on the top-level net.
module grid_io_tile (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] cfg,      // {in_reg, ie_en, oe_en}
  input  logic       pad_i,    // resolved pad value
  output logic       inpad_o,
  output logic       oe_o
);
  logic pad_in_q, pad_in_d;

  assign pad_in_d = pad_i;     // sample every cycle, whatever the config
  assign oe_o     = cfg[0];

  always_ff @(posedge clk) begin
    if (rst) pad_in_q <= 1'b0;
    else     pad_in_q <= pad_in_d;
  end

  always_comb begin
    inpad_o = 1'b0;
    if (cfg[1]) inpad_o = cfg[2] ? pad_in_q : pad_i;
  end
endmodule

module grid_io_param #(
  parameter int NUM_PADS = 8,
  parameter int CFG_BITS = 3
) (
  input  logic                prog_clk,
  input  logic                pReset,
  input  logic                ccff_head,
  input  logic                ccff_shift_en,
  input  logic                ccff_commit,
  output logic                ccff_tail,
  input  logic [NUM_PADS-1:0] io_outpad,
  output logic [NUM_PADS-1:0] io_inpad,
  inout  wire  [NUM_PADS-1:0] gfpga_pad_GPIO_PAD,
  output logic                cfg_valid,
  output logic                cfg_err
);
  localparam int TOTAL = NUM_PADS * CFG_BITS;
  localparam int CNT_W = $clog2(TOTAL + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TOTAL);
  // TOTAL+1 marks an overrun. It is never passed, so an overrun can't wrap back to TOTAL.
  localparam logic [CNT_W-1:0] CNT_OVR  = CNT_W'(TOTAL + 1);

  logic [TOTAL-1:0] chain_q, chain_d;
  logic [TOTAL-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             cfg_valid_q, cfg_valid_d;
  logic             cfg_err_q, cfg_err_d;

  always_comb begin
    chain_d     = chain_q;
    shadow_d    = shadow_q;
    count_d     = count_q;
    cfg_valid_d = cfg_valid_q;
    cfg_err_d   = cfg_err_q;
    if (ccff_commit) begin
      // Commit wins over a simultaneous shift, so the chain holds this cycle.
      count_d = '0;
      if (count_q == CNT_FULL) begin
        shadow_d    = chain_q;
        cfg_valid_d = 1'b1;
        cfg_err_d   = 1'b0;
      end else begin
        cfg_err_d   = 1'b1;
      end
    end else if (ccff_shift_en) begin
      chain_d = {chain_q[TOTAL-2:0], ccff_head};
      if (count_q != CNT_OVR) count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      chain_q     <= '0;
      shadow_q    <= '0;
      count_q     <= '0;
      cfg_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      chain_q     <= chain_d;
      shadow_q    <= shadow_d;
      count_q     <= count_d;
      cfg_valid_q <= cfg_valid_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign ccff_tail = chain_q[TOTAL-1];
  assign cfg_valid = cfg_valid_q;
  assign cfg_err   = cfg_err_q;

  logic [NUM_PADS-1:0] pad_oe;

  for (genvar k = 0; k < NUM_PADS; k++) begin : g_pad
    grid_io_tile u_tile (
      .clk     (prog_clk),
      .rst     (pReset),
      .cfg     (shadow_q[CFG_BITS*k +: 3]),
      .pad_i   (gfpga_pad_GPIO_PAD[k]),
      .inpad_o (io_inpad[k]),
      .oe_o    (pad_oe[k])
    );
    assign gfpga_pad_GPIO_PAD[k] = pad_oe[k] ? io_outpad[k] : 1'bz;
  end
endmodule

// File: tb/tb_grid_io_param.sv
module tb_grid_io_param;
  localparam int NP = 8;

  logic          prog_clk = 1'b0;
  logic          pReset, ccff_head, ccff_shift_en, ccff_commit;
  logic          ccff_tail, cfg_valid, cfg_err;
  logic [NP-1:0] io_outpad, io_inpad;
  logic [NP-1:0] tb_oe, tb_drv;
  wire  [NP-1:0] gpio;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct { string tag; logic [31:0] val; } exp_t;
  exp_t sb[$];

  // A weak pull-up on each pad. An undriven pad then reads 1, and a pad the DUT
  // drives low reads 0, so "is it Z" can be observed.
  for (genvar k = 0; k < NP; k++) begin : g_pad
    pullup pu (gpio[k]);
    assign gpio[k] = tb_oe[k] ? tb_drv[k] : 1'bz;
  end

  grid_io_param #(.NUM_PADS(NP)) dut (
    .prog_clk           (prog_clk),
    .pReset             (pReset),
    .ccff_head          (ccff_head),
    .ccff_shift_en      (ccff_shift_en),
    .ccff_commit        (ccff_commit),
    .ccff_tail          (ccff_tail),
    .io_outpad          (io_outpad),
    .io_inpad           (io_inpad),
    .gfpga_pad_GPIO_PAD (gpio),
    .cfg_valid          (cfg_valid),
    .cfg_err            (cfg_err)
  );

  always #5 prog_clk = ~prog_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty: observed %0h expected none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step();
    @(posedge prog_clk);
    #1;
  endtask

  // Shift the n low bits of vec, MSB first, so a full 24-bit load leaves chain == vec.
  task automatic load(input logic [31:0] vec, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      ccff_shift_en = 1'b1;
      ccff_head     = vec[i];
      step();
    end
    ccff_shift_en = 1'b0;
    ccff_head     = 1'b0;
  endtask

  task automatic commit();
    ccff_commit = 1'b1;
    step();
    ccff_commit = 1'b0;
  endtask

  localparam logic [31:0] VEC2 = 32'h0020_0002; // pad7=001, pad0=010
  localparam logic [31:0] VEC5 = 32'h0021_8C02; // pad7=001 pad5=011 pad3=110 pad0=010
  localparam logic [31:0] VEC6 = 32'h00A1_8C02; // as VEC5 but pad7=101
  localparam logic [31:0] V30  = 32'h15A5_A5A5; // bit23=1, bit22=0

  initial begin
    pReset = 1'b1; ccff_head = 1'b0; ccff_shift_en = 1'b0; ccff_commit = 1'b0;
    io_outpad = '0; tb_oe = '0; tb_drv = '0;

    // 1: reset
    step(); step();
    pReset = 1'b0;
    push("rst_valid", 0); push("rst_err", 0); push("rst_tail", 0);
    push("rst_inpad", 0); push("rst_pads_z", 32'hFF);
    @(negedge prog_clk);
    pop_chk(cfg_valid); pop_chk(cfg_err); pop_chk(ccff_tail);
    pop_chk(io_inpad); pop_chk(gpio);

    // 2: load, chain alone must not touch pads
    load(VEC2, 24);
    push("pre_commit_pads", 32'hFF); push("pre_commit_valid", 0);
    @(negedge prog_clk);
    pop_chk(gpio); pop_chk(cfg_valid);
    tb_oe[0] = 1'b1; tb_drv[0] = 1'b1; io_outpad = 8'h80;
    commit();
    push("c2_valid", 1); push("c2_err", 0); push("c2_pads", 32'hFF); push("c2_inpad", 32'h01);
    @(negedge prog_clk);
    pop_chk(cfg_valid); pop_chk(cfg_err); pop_chk(gpio); pop_chk(io_inpad);
    step();
    io_outpad = 8'h00;
    push("c2_pad7_driven", 32'h7F);
    @(negedge prog_clk);
    pop_chk(gpio);

    // 3: short load rejected, err sticky, then recovered
    load(32'hFFFF_FFFF, 23);
    commit();
    push("short_err", 1); push("short_valid", 1); push("short_pads", 32'h7F); push("short_inpad", 32'h01);
    @(negedge prog_clk);
    pop_chk(cfg_err); pop_chk(cfg_valid); pop_chk(gpio); pop_chk(io_inpad);
    step();
    push("err_sticky", 1);
    @(negedge prog_clk);
    pop_chk(cfg_err);
    load(VEC2, 24);
    commit();
    push("retry_err", 0);
    @(negedge prog_clk);
    pop_chk(cfg_err);

    // 4: overrun
    load(V30, 30);
    push("ovr_tail", 1);
    @(negedge prog_clk);
    pop_chk(ccff_tail);
    commit();
    push("ovr_err", 1); push("ovr_pads", 32'h7F); push("ovr_inpad", 32'h01);
    @(negedge prog_clk);
    pop_chk(cfg_err); pop_chk(gpio); pop_chk(io_inpad);

    // 5: registered vs direct input, loopback
    tb_oe = 8'h09; tb_drv = 8'h00; io_outpad = 8'h20;
    load(VEC5, 24);
    commit();
    push("c5_err", 0); push("c5_inpad", 32'h20);
    @(negedge prog_clk);
    pop_chk(cfg_err); pop_chk(io_inpad);
    step();
    tb_drv = 8'h09; io_outpad = 8'h00;
    push("reg_t", 32'h01);
    @(negedge prog_clk);
    pop_chk(io_inpad);
    step();
    push("reg_t1", 32'h09);
    @(negedge prog_clk);
    pop_chk(io_inpad);
    step();
    io_outpad = 8'h20;
    push("loopback", 32'h29);
    @(negedge prog_clk);
    pop_chk(io_inpad);

    // 6a: shift+commit together: commit taken, chain holds
    io_outpad = 8'h00;
    load(VEC6, 24);
    ccff_shift_en = 1'b1; ccff_head = 1'b0;
    commit();
    ccff_shift_en = 1'b0;
    push("coll_err", 0); push("coll_tail", 1); push("coll_inpad", 32'h09);
    @(negedge prog_clk);
    pop_chk(cfg_err); pop_chk(ccff_tail); pop_chk(io_inpad);
    commit();
    push("coll_cnt_cleared", 1);
    @(negedge prog_clk);
    pop_chk(cfg_err);

    // 6b: reset mid-load
    tb_oe = '0; tb_drv = '0; io_outpad = '0;
    load(VEC2, 12);
    pReset = 1'b1;
    step();
    pReset = 1'b0;
    push("mid_valid", 0); push("mid_err", 0); push("mid_tail", 0);
    push("mid_inpad", 0); push("mid_pads_z", 32'hFF);
    @(negedge prog_clk);
    pop_chk(cfg_valid); pop_chk(cfg_err); pop_chk(ccff_tail);
    pop_chk(io_inpad); pop_chk(gpio);
    commit();
    push("post_rst_commit_err", 1);
    @(negedge prog_clk);
    pop_chk(cfg_err);
    load(VEC2, 24);
    commit();
    push("post_rst_reload_err", 0); push("post_rst_reload_valid", 1);
    @(negedge prog_clk);
    pop_chk(cfg_err); pop_chk(cfg_valid);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
